odo_display: RTL and testbench

Display-side reader for the odometer's fixed-point distance output. It watches `odo_int` (integer units) and `odo_point` (sixteenths). On every change it converts the value to BCD with a sequential shift-add-3 engine, producing three integer digits plus one decimal digit. It then time-multiplexes the committed digits onto a 4-digit seven-segment display, and sits between the odometer and the board's display pins.

---
 rtl/odo_display.sv | 154 +++++++++++++++
 tb/tb_odo_display.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/odo_display.sv
// Odometer display reader: converts {odo_int, odo_point} to BCD on every change
// with a sequential double-dabble engine, then multiplexes the digits onto a 4-digit 7-seg display.
module odo_display #(
    parameter int unsigned REFRESH_DIV = 1000
) (
    input  logic       clock,
    input  logic       nRst,
    input  logic [9:0] odo_int,
    input  logic [3:0] odo_point,
    output logic       busy,
    output logic [3:0] bcd_h,
    output logic [3:0] bcd_t,
    output logic [3:0] bcd_u,
    output logic [3:0] bcd_f,
    output logic [3:0] digit_en,
    output logic [6:0] seg,
    output logic       dp
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t      state_reg;
    logic [13:0] last_reg;
    logic [9:0]  bin_reg;
    logic [11:0] bcd_reg;
    logic [3:0]  iter_reg;
    logic [15:0] refresh_reg;

    logic [11:0] bcd_adj;
    logic [7:0]  frac_x10;
    logic        clamp;
    logic [3:0]  digit_next;
    logic [3:0]  sel_digit;
    logic        sel_blank;
    logic [6:0]  seg_next;

    // Add-3 correction applied to every nibble before each shift
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
        assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                    bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end

    assign frac_x10   = {4'd0, last_reg[3:0]} * 8'd10;
    assign clamp      = last_reg[13:4] > 10'd999;
    assign digit_next = {digit_en[2:0], digit_en[3]};

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // Digit about to be selected on the next refresh wrap, with leading-zero blanking
    always_comb begin
        sel_digit = bcd_f;
        sel_blank = 1'b0;
        case (digit_next)
            4'b0010: sel_digit = bcd_u;
            4'b0100: begin
                sel_digit = bcd_t;
                sel_blank = (bcd_h == 4'd0) && (bcd_t == 4'd0);
            end
            4'b1000: begin
                sel_digit = bcd_h;
                sel_blank = (bcd_h == 4'd0);
            end
            default: sel_digit = bcd_f;
        endcase
        seg_next = sel_blank ? 7'h00 : seg_decode(sel_digit);
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            state_reg <= IDLE;
            last_reg  <= '0;
            bin_reg   <= '0;
            bcd_reg   <= '0;
            iter_reg  <= '0;
            busy      <= 1'b0;
            bcd_h     <= '0;
            bcd_t     <= '0;
            bcd_u     <= '0;
            bcd_f     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if ({odo_int, odo_point} != last_reg) begin
                        last_reg  <= {odo_int, odo_point};
                        bin_reg   <= odo_int;
                        bcd_reg   <= '0;
                        iter_reg  <= '0;
                        busy      <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_reg  <= {bcd_adj[10:0], bin_reg[9]};
                    bin_reg  <= {bin_reg[8:0], 1'b0};
                    iter_reg <= iter_reg + 4'd1;
                    if (iter_reg == 4'd9) begin
                        state_reg <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (clamp) begin
                        bcd_h <= 4'd9;
                        bcd_t <= 4'd9;
                        bcd_u <= 4'd9;
                        bcd_f <= 4'd9;
                    end else begin
                        bcd_h <= bcd_reg[11:8];
                        bcd_t <= bcd_reg[7:4];
                        bcd_u <= bcd_reg[3:0];
                        bcd_f <= frac_x10[7:4];
                    end
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Refresh multiplexer: seg/dp are loaded together with digit_en on each wrap
    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            refresh_reg <= '0;
            digit_en    <= 4'b0001;
            seg         <= 7'h3F;
            dp          <= 1'b0;
        end else if (refresh_reg == 16'(REFRESH_DIV - 1)) begin
            refresh_reg <= '0;
            digit_en    <= digit_next;
            seg         <= seg_next;
            dp          <= digit_next[1];
        end else begin
            refresh_reg <= refresh_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_odo_display.sv
// Bench for odo_display: arithmetic reference model checked every cycle,
// plus directed scenarios with literal digit and segment expectations.
module tb_odo_display;

    localparam int R = 3;

    logic       clock;
    logic       nRst;
    logic [9:0] odo_int;
    logic [3:0] odo_point;
    logic       busy;
    logic [3:0] bcd_h, bcd_t, bcd_u, bcd_f;
    logic [3:0] digit_en;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    odo_display #(.REFRESH_DIV(R)) dut (
        .clock     (clock),
        .nRst      (nRst),
        .odo_int   (odo_int),
        .odo_point (odo_point),
        .busy      (busy),
        .bcd_h     (bcd_h),
        .bcd_t     (bcd_t),
        .bcd_u     (bcd_u),
        .bcd_f     (bcd_f),
        .digit_en  (digit_en),
        .seg       (seg),
        .dp        (dp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] pattern(input int d);
        case (d)
            0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
            4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
            8: return 7'h7F; 9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Position 0 = decimal ... 3 = hundreds
    function automatic logic [6:0] shown(input int pos, input int h, input int t, input int u, input int f);
        case (pos)
            0: return pattern(f);
            1: return pattern(u);
            2: return (h == 0 && t == 0) ? 7'h00 : pattern(t);
            default: return (h == 0) ? 7'h00 : pattern(h);
        endcase
    endfunction

    // which: 3=hundreds 2=tens 1=units 0=decimal
    function automatic int conv_digit(input logic [13:0] s, input int which);
        int v;
        int p;
        v = int'(s[13:4]);
        p = int'(s[3:0]);
        if (v > 999) return 9;
        case (which)
            3: return v / 100;
            2: return (v / 10) % 10;
            1: return v % 10;
            default: return (p * 10) / 16;
        endcase
    endfunction

    // Reference model
    logic [13:0] m_last;
    int          m_timer;
    logic        m_busy;
    int          m_h, m_t, m_u, m_f;
    int          m_cyc;
    logic [6:0]  m_seg;

    always @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            m_last  <= '0;
            m_timer <= 0;
            m_busy  <= 1'b0;
            m_h <= 0; m_t <= 0; m_u <= 0; m_f <= 0;
            m_cyc   <= 0;
            m_seg   <= 7'h3F;
        end else begin
            m_cyc <= m_cyc + 1;
            if ((m_cyc + 1) % R == 0)
                m_seg <= shown(((m_cyc + 1) / R) % 4, m_h, m_t, m_u, m_f);
            if (m_timer == 0) begin
                if ({odo_int, odo_point} != m_last) begin
                    m_last  <= {odo_int, odo_point};
                    m_timer <= 11;
                    m_busy  <= 1'b1;
                end
            end else begin
                m_timer <= m_timer - 1;
                if (m_timer == 1) begin
                    m_busy <= 1'b0;
                    m_h <= conv_digit(m_last, 3);
                    m_t <= conv_digit(m_last, 2);
                    m_u <= conv_digit(m_last, 1);
                    m_f <= conv_digit(m_last, 0);
                end
            end
        end
    end

    always @(negedge clock) begin
        chk("cmp_busy", busy, m_busy);
        chk("cmp_bcd_h", bcd_h, m_h);
        chk("cmp_bcd_t", bcd_t, m_t);
        chk("cmp_bcd_u", bcd_u, m_u);
        chk("cmp_bcd_f", bcd_f, m_f);
        chk("cmp_digit_en", digit_en, 1 << ((m_cyc / R) % 4));
        chk("cmp_seg", seg, m_seg);
        chk("cmp_dp", dp, ((m_cyc / R) % 4) == 1);
    end

    task automatic wait_conv(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (busy) n++;
            else if (n > 0) break;
        end
    endtask

    task automatic check_digits(input string name, input int h, input int t, input int u, input int f);
        chk({name, "_h"}, bcd_h, h);
        chk({name, "_t"}, bcd_t, t);
        chk({name, "_u"}, bcd_u, u);
        chk({name, "_f"}, bcd_f, f);
        $display("%s: bcd=%0d,%0d,%0d,%0d", name, bcd_h, bcd_t, bcd_u, bcd_f);
    endtask

    task automatic check_frame(input string name, input logic [6:0] sh, input logic [6:0] st,
                               input logic [6:0] su, input logic [6:0] sf);
        logic [6:0] exp_seg [4];
        bit found;
        exp_seg[0] = sf; exp_seg[1] = su; exp_seg[2] = st; exp_seg[3] = sh;
        repeat (4 * R) @(negedge clock);
        for (int p = 0; p < 4; p++) begin
            found = 0;
            for (int i = 0; i < 8 * R && !found; i++) begin
                @(negedge clock);
                if (digit_en == 4'(1 << p)) found = 1;
            end
            chk({name, "_sel"}, found, 1);
            chk({name, "_seg"}, seg, exp_seg[p]);
            chk({name, "_dp"}, dp, p == 1);
        end
        $display("%s: frame checked", name);
    endtask

    task automatic convert(input string name, input int iv, input int pv, output int n);
        @(negedge clock);
        odo_int   = 10'(iv);
        odo_point = 4'(pv);
        wait_conv(n);
        chk({name, "_busy_len"}, n, 11);
    endtask

    int n;

    initial begin
        nRst      = 1'b1;
        odo_int   = '0;
        odo_point = '0;
        #1 nRst = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 0);
        check_digits("rst", 0, 0, 0, 0);
        chk("rst_digit_en", digit_en, 4'b0001);
        chk("rst_seg", seg, 7'h3F);
        chk("rst_dp", dp, 0);
        nRst = 1'b1;
        repeat (5) @(negedge clock);
        chk("idle_busy", busy, 0);
        check_frame("rst_frame", 7'h00, 7'h00, 7'h3F, 7'h3F);

        convert("c123", 123, 8, n);
        check_digits("c123", 1, 2, 3, 5);
        check_frame("c123_frame", 7'h06, 7'h5B, 7'h4F, 7'h6D);

        convert("c7", 7, 15, n);
        check_digits("c7", 0, 0, 7, 9);
        check_frame("c7_frame", 7'h00, 7'h00, 7'h07, 7'h6F);

        convert("c1000", 1000, 2, n);
        check_digits("c1000", 9, 9, 9, 9);
        check_frame("c1000_frame", 7'h6F, 7'h6F, 7'h6F, 7'h6F);

        convert("c999", 999, 1, n);
        check_digits("c999", 9, 9, 9, 0);
        check_frame("c999_frame", 7'h6F, 7'h6F, 7'h6F, 7'h3F);

        // Input change during SHIFT is deferred until the next IDLE cycle
        @(negedge clock);
        odo_int = 10'd45; odo_point = 4'd0;
        @(posedge clock);
        repeat (3) @(posedge clock);
        #1 odo_int = 10'd46;
        wait_conv(n);
        chk("c45_busy_rest", n, 8);
        check_digits("c45", 0, 4, 5, 0);
        wait_conv(n);
        chk("c46_busy_len", n, 11);
        check_digits("c46", 0, 4, 6, 0);

        // Asynchronous reset in the middle of a conversion
        @(negedge clock);
        odo_int = 10'd321; odo_point = 4'd4;
        @(posedge clock);
        repeat (5) @(posedge clock);
        #1 nRst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        check_digits("mid_rst", 0, 0, 0, 0);
        chk("mid_rst_digit_en", digit_en, 4'b0001);
        chk("mid_rst_seg", seg, 7'h3F);
        chk("mid_rst_dp", dp, 0);
        @(negedge clock);
        nRst = 1'b1;
        wait_conv(n);
        chk("c321_busy_len", n, 11);
        check_digits("c321", 3, 2, 1, 2);
        check_frame("c321_frame", 7'h4F, 7'h5B, 7'h06, 7'h5B);

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
